shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

- Multi-pass sequencer sitting directly upstream of the 4-bit `barrel_shifter`. It drives that shifter's inputs and consumes its output.
- Accepts a 4-bit word plus an arbitrary shift/rotate amount over a valid/ready handshake.
- The shifter moves at most 3 positions per pass, so the amount is split into passes. Each pass result is fed back through the shifter until the amount is exhausted.
- The final word is returned on a valid/ready output handshake.

## Interface
Parameters:
- AMT_W, 8: width of requested amount; legal amounts 0 .. 2^AMT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  high only in IDLE.
- in_data  in  4  word to shift.
- in_amt  in  AMT_W  total positions.
- in_dir  in  1  0 = left, 1 = right.
- in_op  in  1  0 = logical shift (zero fill), 1 = rotate.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- out_data  out  4  result.
- bs_d_in  out  4  to barrel_shifter d_in.
- bs_sel_in  out  2  to barrel_shifter sel_in.
- bs_shift_dir  out  1  to barrel_shifter shift_dir.
- bs_operation  out  1  to barrel_shifter operation.
- bs_d_out  in  4  from barrel_shifter d_out; combinational, same cycle.

## Operation
Registers:
- state ∈ {IDLE, RUN, DONE}
- acc[3:0]
- rem[AMT_W-1:0]
- dir, op

States:
- **IDLE:** in_ready=1. On in_valid: acc←in_data, rem←in_amt, dir←in_dir, op←in_op. Next state RUN if in_amt≠0, else DONE.
- **RUN:** sel = min(rem,3). Drive bs_d_in=acc, bs_sel_in=sel, bs_shift_dir=dir, bs_operation=op. Each edge: acc←bs_d_out, rem←rem−sel. When rem−sel==0, go to DONE.
- **DONE:** out_valid=1, out_data=acc. On out_ready, go to IDLE.

Outside RUN:
- bs_sel_in=0 and bs_d_in=acc.
- bs_shift_dir and bs_operation follow the registered dir and op.

Handshake rules:
- No overlap: in_ready=0 in both RUN and DONE.
- in_valid is ignored outside IDLE.
- out_data is stable while out_valid=1 and out_ready=0.

Pass count and arithmetic:
- P = ceil(in_amt/3).
- rem never underflows, because sel ≤ rem.
- Amount 0 gives zero passes; the word is returned unchanged.

Reset values (asynchronous, valid immediately on rst_n low, including mid-RUN):
- state=IDLE, acc=0, rem=0, dir=0, op=0.
- out_valid=0, in_ready=1, out_data=0, bs_*=0.
- Any in-flight request is discarded.

## Timing
- Edge 0 is the accepting edge.
- out_valid rises after edge P.
- Minimum latency: one cycle, for amount 0.
- Throughput: one request per P+2 cycles when out_ready is held high.
- Back-to-back: out_ready at edge k returns the block to IDLE; the next request can be accepted at edge k+1.

## Configuration
Macro: SHIFT_SEQ_SHORTCUT_EN.

Defined:
- At acceptance, rotate amounts reduce to in_amt mod 4.
- Logical shifts with in_amt ≥ 4 load acc←0 and go directly to DONE (P=0).
- Result: P ≤ 1 always.

Undefined:
- Full iteration, P = ceil(in_amt/3), for all requests.

Both builds produce identical out_data for every request; only latency differs.

## Structure
- Package shift_seq_pkg holds:
  - DATA_W=4 and SEL_MAX=3.
  - state enum seq_state_t {IDLE, RUN, DONE}.
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
  - op constants OP_SHIFT=0, OP_ROTATE=1.
- No sub-module; `barrel_shifter` is instantiated beside this block in the parent and wired through the bs_* ports.

## Test plan
Each scenario drives `barrel_shifter` through the bs_* ports.

- **Amount 0:** in_data=1101, in_amt=0 -> out_data=1101; out_valid after edge 0; bs_sel_in stays 0.
- **Rotate left:** in_data=1001, in_amt=5, in_op=1, in_dir=0 -> out_data=0011.
  - Macro undefined: passes sel=3 then sel=2, out_valid after edge 2.
  - Macro defined: single pass sel=1, out_valid after edge 1.
- **Logical shift right:** in_data=1101, in_amt=2, in_op=0, in_dir=1 -> out_data=0011 after edge 1.
- **Logical shift left:** in_data=1101, in_amt=7, in_op=0, in_dir=0 -> out_data=0000.
  - Macro undefined: passes 3, 3, 1, out_valid after edge 3.
  - Macro defined: out_valid after edge 0.
- **Backpressure:** out_ready low for 3 cycles while in_valid pulses -> out_data held, in_ready=0, pulses ignored; one cycle after out_ready rises, in_ready=1.
- **Reset mid-run:** rst_n low during RUN of in_data=1101, in_amt=200, in_op=1, in_dir=1 -> immediately state IDLE, out_valid=0, in_ready=1, acc=0; a following request with in_amt=2 completes normally.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared constants and state type for the multi-pass shift sequencer.
package shift_seq_pkg;

   localparam int DATA_W  = 4;
   localparam int SEL_MAX = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic OP_SHIFT  = 1'b0;
   localparam logic OP_ROTATE = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Multi-pass sequencer feeding an external 4-bit barrel shifter (max 3 positions/pass).
// Optional SHIFT_SEQ_SHORTCUT_EN reduces amounts at acceptance so at most one pass runs.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int AMT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AMT_W-1:0]  in_amt,
   input  logic              in_dir,
   input  logic              in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] bs_d_in,
   output logic [1:0]        bs_sel_in,
   output logic              bs_shift_dir,
   output logic              bs_operation,
   input  logic [DATA_W-1:0] bs_d_out
);

   seq_state_t        r_state;
   logic [DATA_W-1:0] r_acc;
   logic [AMT_W-1:0]  r_rem;
   logic              r_dir;
   logic              r_op;

   logic [1:0]        w_sel;
   logic [AMT_W-1:0]  w_rem_next;
   logic [AMT_W-1:0]  w_load_amt;
   logic [DATA_W-1:0] w_load_data;

   always_comb begin
      w_sel      = (r_rem > AMT_W'(SEL_MAX)) ? 2'(SEL_MAX) : r_rem[1:0];
      w_rem_next = r_rem - AMT_W'(w_sel);
   end

   always_comb begin
      w_load_amt  = in_amt;
      w_load_data = in_data;
`ifdef SHIFT_SEQ_SHORTCUT_EN
      // A 4-bit rotate repeats every 4; a logical shift of 4+ clears the word.
      if (in_op == OP_ROTATE) begin
         w_load_amt = AMT_W'(in_amt[1:0]);
      end else if (in_amt > AMT_W'(SEL_MAX)) begin
         w_load_amt  = '0;
         w_load_data = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_rem   <= '0;
         r_dir   <= 1'b0;
         r_op    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_acc   <= w_load_data;
                  r_rem   <= w_load_amt;
                  r_dir   <= in_dir;
                  r_op    <= in_op;
                  r_state <= (w_load_amt != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               r_acc <= bs_d_out;
               r_rem <= w_rem_next;
               if (w_rem_next == '0) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state == IDLE);
   assign out_valid    = (r_state == DONE);
   assign out_data     = r_acc;
   assign bs_d_in      = r_acc;
   assign bs_sel_in    = (r_state == RUN) ? w_sel : 2'd0;
   assign bs_shift_dir = r_dir;
   assign bs_operation = r_op;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural barrel shifter on the bs_* ports.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic [7:0] in_amt = '0;
   logic       in_dir = 1'b0;
   logic       in_op = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [3:0] bs_d_in;
   logic [1:0] bs_sel_in;
   logic       bs_shift_dir;
   logic       bs_operation;
   logic [3:0] bs_d_out;

   int n_total = 0;
   int n_bad   = 0;

   shift_seq_ctrl #(.AMT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_dir(in_dir), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .bs_d_in(bs_d_in), .bs_sel_in(bs_sel_in), .bs_shift_dir(bs_shift_dir),
      .bs_operation(bs_operation), .bs_d_out(bs_d_out)
   );

   always #5 clk = ~clk;

   // Barrel shifter: one position at a time, sel times.
   function automatic logic [3:0] bs_model(input logic [3:0] d, input logic [1:0] sel,
                                           input logic dir, input logic op);
      logic [3:0] v;
      v = d;
      for (int i = 0; i < int'(sel); i++) begin
         if (dir) v = {op ? v[0] : 1'b0, v[3:1]};
         else     v = {v[2:0], op ? v[3] : 1'b0};
      end
      return v;
   endfunction

   always_comb bs_d_out = bs_model(bs_d_in, bs_sel_in, bs_shift_dir, bs_operation);

   // Reference: total effect of the whole request in one step.
   function automatic logic [3:0] ref_result(input logic [3:0] d, input logic [7:0] a,
                                             input logic dir, input logic op);
      logic [7:0]  dbl;
      logic [31:0] w;
      int          r;
      if (op) begin
         r   = int'(a) % 4;
         dbl = {d, d};
         if (dir) dbl = dbl >> r;
         else     dbl = dbl << r;
         return dir ? dbl[3:0] : dbl[7:4];
      end
      w = {28'd0, d};
      if (dir) w = w >> a;
      else     w = w << a;
      return w[3:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_req(input logic [3:0] d, input logic [7:0] a, input logic dr,
                         input logic o, input int bp);
      logic [3:0] exp_d;
      int eff, p, lat, last;
      exp_d = ref_result(d, a, dr, o);
      eff   = int'(a);
`ifdef SHIFT_SEQ_SHORTCUT_EN
      if (o) eff = int'(a) % 4;
      else if (a > 8'd3) eff = 0;
`endif
      p    = (eff + 2) / 3;
      last = eff - 3 * (p - 1);
      chk("in_ready_idle", in_ready, 1);
      in_data = d; in_amt = a; in_dir = dr; in_op = o; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 400) begin
         chk("pass_sel", bs_sel_in, (lat < p - 1) ? 3 : last);
         chk("run_in_ready", in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, p);
      chk("done_sel", bs_sel_in, 0);
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 4'($urandom);
         in_amt   = 8'($urandom);
         @(posedge clk); #1;
         chk("bp_hold", out_data, exp_d);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      chk("out_valid", out_valid, 1);
      chk("result", out_data, exp_d);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("back_idle", in_ready, 1);
      chk("valid_clr", out_valid, 0);
   endtask

   initial begin
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_bs", {bs_d_in, bs_sel_in, bs_shift_dir, bs_operation}, 0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      do_req(4'b1101, 8'd0, 1'b0, 1'b0, 0);
      do_req(4'b1001, 8'd5, 1'b0, 1'b1, 0);
      do_req(4'b1101, 8'd2, 1'b1, 1'b0, 0);
      do_req(4'b1101, 8'd7, 1'b0, 1'b0, 0);
      do_req(4'b1011, 8'd3, 1'b1, 1'b1, 3);
      do_req(4'b0110, 8'd255, 1'b1, 1'b1, 1);
      do_req(4'b1000, 8'd4, 1'b0, 1'b1, 0);

      // Asynchronous reset in the middle of a long rotate.
      in_data = 4'b1101; in_amt = 8'd200; in_dir = 1'b1; in_op = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_acc", out_data, 0);
      chk("mid_rst_bs", {bs_d_in, bs_sel_in, bs_shift_dir, bs_operation}, 0);
      @(posedge clk); #1;
      chk("held_rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(4'b1101, 8'd2, 1'b1, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         do_req(4'($urandom), (n % 3 == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
